tff_toggle_arbiter: RTL and testbench

TFF_TOGGLE_ARBITER -- requirements
Module: tff_toggle_arbiter

---
 rtl/tff_toggle_arbiter.sv | 109 ++++++++++
 tb/tb_tff_toggle_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/tff_toggle_arbiter.sv
// Round-robin arbiter that grants one requester at a time a single toggle of the shared T flip-flop q.
// Define TOGGLE_CNT_EN to add the toggle_cnt port, which counts applied toggles.
module tff_toggle_arbiter #(
  parameter int NREQ    = 4,
  parameter int HOLDOFF = 2,
  parameter int CNT_W   = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            tin,
  output logic            q,
  output logic            busy
`ifdef TOGGLE_CNT_EN
  ,
  output logic [CNT_W-1:0] toggle_cnt
`endif
);

  localparam int IDX_W = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] arb_idx;
  logic            arb_found;
  logic [NREQ-1:0] arb_onehot;
  logic [3:0]      hold_cnt;
  int              scan;

  // Scan upward from ptr with wrap-around; the first pending request wins.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    scan      = 0;
    for (int i = 0; i < NREQ; i++) begin
      scan = (int'(ptr) + i) % NREQ;
      if (!arb_found && req[IDX_W'(scan)]) begin
        arb_found = 1'b1;
        arb_idx   = IDX_W'(scan);
      end
    end
    arb_onehot = NREQ'(1) << arb_idx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      gnt      <= '0;
      tin      <= 1'b0;
      q        <= 1'b0;
      ptr      <= '0;
      win_idx  <= '0;
      hold_cnt <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= '0;
      tin   <= 1'b0;
      case (state)
        IDLE: begin
          if (state_nxt == GRANT) begin
            gnt     <= arb_onehot;
            tin     <= 1'b1;
            win_idx <= arb_idx;
          end
        end
        GRANT: begin
          q        <= ~q;
          ptr      <= (win_idx == IDX_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
          hold_cnt <= 4'(HOLDOFF);
        end
        HOLD: begin
          hold_cnt <= (hold_cnt == 4'd0) ? 4'd0 : hold_cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

  // HOLD leaves on its last counted cycle so it lasts exactly HOLDOFF cycles.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (arb_found) state_nxt = GRANT;
      GRANT:   state_nxt = (HOLDOFF > 0) ? HOLD : IDLE;
      HOLD:    if (hold_cnt <= 4'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

`ifdef TOGGLE_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      toggle_cnt <= '0;
    end else if (state == GRANT) begin
      toggle_cnt <= toggle_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_tff_toggle_arbiter.sv
// Directed bench for tff_toggle_arbiter: a cycle table for arbitration/holdoff behaviour,
// plus sequences for mid-grant reset and a HOLDOFF=0 instance.
module tb_tff_toggle_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       tin;
  logic       q;
  logic       busy;
  logic [3:0] req0;
  logic [3:0] gnt0;
  logic       tin0;
  logic       q0;
  logic       busy0;
`ifdef TOGGLE_CNT_EN
  logic [1:0] cnt;
  logic [1:0] cnt0;
`endif

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic       tin;
    logic       q;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  tff_toggle_arbiter #(.NREQ(4), .HOLDOFF(2), .CNT_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .gnt   (gnt),
    .tin   (tin),
    .q     (q),
    .busy  (busy)
`ifdef TOGGLE_CNT_EN
    ,
    .toggle_cnt (cnt)
`endif
  );

  tff_toggle_arbiter #(.NREQ(4), .HOLDOFF(0), .CNT_W(2)) dut0 (
    .clk   (clk),
    .reset (reset),
    .req   (req0),
    .gnt   (gnt0),
    .tin   (tin0),
    .q     (q0),
    .busy  (busy0)
`ifdef TOGGLE_CNT_EN
    ,
    .toggle_cnt (cnt0)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic [3:0] r);
    req = r;
    @(posedge clk);
    #1;
  endtask

  function automatic void addVec(input logic [3:0] r, input logic [3:0] g,
                                 input logic t, input logic qq, input logic b);
    vec_t v;
    v.req  = r;
    v.gnt  = g;
    v.tin  = t;
    v.q    = qq;
    v.busy = b;
    vecs.push_back(v);
  endfunction

  initial begin
    // Continuous cycle-by-cycle run from reset release: {req, gnt, tin, q, busy}.
    addVec(4'hF, 4'h1, 1, 0, 1); addVec(4'hF, 4'h0, 0, 1, 1);
    addVec(4'hF, 4'h0, 0, 1, 1); addVec(4'hF, 4'h0, 0, 1, 0);
    addVec(4'hF, 4'h2, 1, 1, 1); addVec(4'hF, 4'h0, 0, 0, 1);
    addVec(4'hF, 4'h0, 0, 0, 1); addVec(4'hF, 4'h0, 0, 0, 0);
    addVec(4'hF, 4'h4, 1, 0, 1); addVec(4'hF, 4'h0, 0, 1, 1);
    addVec(4'hF, 4'h0, 0, 1, 1); addVec(4'hF, 4'h0, 0, 1, 0);
    addVec(4'hF, 4'h8, 1, 1, 1); addVec(4'hF, 4'h0, 0, 0, 1);
    addVec(4'hF, 4'h0, 0, 0, 1); addVec(4'hF, 4'h0, 0, 0, 0);
    addVec(4'hF, 4'h1, 1, 0, 1); addVec(4'hF, 4'h0, 0, 1, 1);
    addVec(4'h0, 4'h0, 0, 1, 1); addVec(4'h0, 4'h0, 0, 1, 0);
    addVec(4'h0, 4'h0, 0, 1, 0);
    // Request withdrawn right after being sampled still gets its toggle.
    addVec(4'h4, 4'h4, 1, 1, 1); addVec(4'h0, 4'h0, 0, 0, 1);
    addVec(4'h0, 4'h0, 0, 0, 1); addVec(4'h0, 4'h0, 0, 0, 0);
    // Pointer at 3 with req=1001: index 3 first, then wrap to 0.
    addVec(4'h9, 4'h8, 1, 0, 1); addVec(4'h9, 4'h0, 0, 1, 1);
    addVec(4'h9, 4'h0, 0, 1, 1); addVec(4'h9, 4'h0, 0, 1, 0);
    addVec(4'h9, 4'h1, 1, 1, 1); addVec(4'h0, 4'h0, 0, 0, 1);
    addVec(4'h0, 4'h0, 0, 0, 1); addVec(4'h0, 4'h0, 0, 0, 0);
    // A request raised only during HOLD is never sampled and is lost.
    addVec(4'h2, 4'h2, 1, 0, 1); addVec(4'h8, 4'h0, 0, 1, 1);
    addVec(4'h8, 4'h0, 0, 1, 1); addVec(4'h0, 4'h0, 0, 1, 0);
    addVec(4'h0, 4'h0, 0, 1, 0);

    reset = 1'b0;
    req   = 4'h0;
    req0  = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset gnt", gnt, 4'h0);
    checkOutput("reset tin", {3'b0, tin}, 4'h0);
    checkOutput("reset q", {3'b0, q}, 4'h0);
    checkOutput("reset busy", {3'b0, busy}, 4'h0);
`ifdef TOGGLE_CNT_EN
    checkOutput("reset toggle_cnt", {2'b0, cnt}, 4'h0);
`endif

    req = 4'hF;
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].req);
      checkOutput($sformatf("row%0d gnt", i), gnt, vecs[i].gnt);
      checkOutput($sformatf("row%0d tin", i), {3'b0, tin}, {3'b0, vecs[i].tin});
      checkOutput($sformatf("row%0d q", i), {3'b0, q}, {3'b0, vecs[i].q});
      checkOutput($sformatf("row%0d busy", i), {3'b0, busy}, {3'b0, vecs[i].busy});
    end

    // Reset asserted in the middle of a GRANT cycle.
    applyStimulus(4'h1);
    checkOutput("pre-reset gnt", gnt, 4'h1);
    checkOutput("pre-reset q", {3'b0, q}, 4'h1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("midgrant gnt", gnt, 4'h0);
    checkOutput("midgrant tin", {3'b0, tin}, 4'h0);
    checkOutput("midgrant q", {3'b0, q}, 4'h0);
    checkOutput("midgrant busy", {3'b0, busy}, 4'h0);
`ifdef TOGGLE_CNT_EN
    checkOutput("midgrant toggle_cnt", {2'b0, cnt}, 4'h0);
`endif
    req = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("held reset q", {3'b0, q}, 4'h0);
    checkOutput("held reset busy", {3'b0, busy}, 4'h0);
    req = 4'h6;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("release gnt", gnt, 4'h2);
    checkOutput("release tin", {3'b0, tin}, 4'h1);
    checkOutput("release q", {3'b0, q}, 4'h0);
    @(posedge clk);
    #1;
    checkOutput("release toggle q", {3'b0, q}, 4'h1);
    checkOutput("release hold busy", {3'b0, busy}, 4'h1);

    // HOLDOFF=0 instance: one toggle every second cycle.
    @(negedge clk);
    reset = 1'b0;
    req   = 4'h0;
    req0  = 4'h2;
    #1;
    checkOutput("h0 reset busy", {3'b0, busy0}, 4'h0);
`ifdef TOGGLE_CNT_EN
    checkOutput("h0 reset toggle_cnt", {2'b0, cnt0}, 4'h0);
`endif
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("h0 edge%0d tin", k), {3'b0, tin0}, {3'b0, k[0]});
      checkOutput($sformatf("h0 edge%0d busy", k), {3'b0, busy0}, {3'b0, k[0]});
      checkOutput($sformatf("h0 edge%0d gnt", k), gnt0, k[0] ? 4'h2 : 4'h0);
      checkOutput($sformatf("h0 edge%0d q", k), {3'b0, q0}, {3'b0, ((k / 2) % 2) == 1});
`ifdef TOGGLE_CNT_EN
      checkOutput($sformatf("h0 edge%0d toggle_cnt", k), {2'b0, cnt0}, 4'((k / 2) % 4));
`endif
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
